// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared types and constants for the branch update scheduler.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_pkg;

  // PC width used unless a parent overrides it
  localparam int DEFAULT_PC_WIDTH = 32;

  // Scheduler control state
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } sched_state_e;

  // One in-flight branch record at the default PC width
  typedef struct packed {
    logic [DEFAULT_PC_WIDTH-1:0] pc;
    logic                        pred;
  } inflight_entry_t;

endpackage

`default_nettype wire

// File: rtl/inflight_fifo.sv
// ---------------------------------------------------------------------------
// inflight_fifo
//   Synchronous circular FIFO with push, pop and a single-cycle clear.
//   Clear wins over push and pop in the same cycle.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inflight_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer/occupancy next state; pointers wrap naturally at a power-of-2 depth
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/branch_update_scheduler.sv
// ---------------------------------------------------------------------------
// branch_update_scheduler
//   Shares the predictor's single pc_bits/update port between fetch lookups
//   and execute resolutions, tracks in-flight branches in order, and flags
//   mispredictions with a registered pulse plus saturating statistics.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_update_scheduler
  import branch_pkg::*;
#(
  parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [PC_WIDTH-1:0]    fetch_pc,
  output logic                   fetch_ready,
  output logic                   fetch_taken,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  output logic                   resolve_ready,
  input  logic                   flush,
  output logic [PC_WIDTH-1:0]    pred_pc_bits,
  input  logic                   pred_prediction,
  output logic                   pred_update_en,
  output logic                   pred_outcome,
  output logic                   mispredict,
  output logic [PC_WIDTH-1:0]    mispredict_pc,
  output logic [$clog2(DEPTH):0] inflight_count,
  output logic [CNT_WIDTH-1:0]   resolved_total,
  output logic [CNT_WIDTH-1:0]   mispredict_total
);

  localparam int EW = PC_WIDTH + 1;  // {pc, pred}

  sched_state_e          state_q, state_d;
  logic                  upd, lkp, mis_now, q_clear;
  logic                  q_full, q_empty;
  logic [EW-1:0]         q_head;
  logic [PC_WIDTH-1:0]   head_pc;
  logic                  head_pred;
  logic                  mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0]   mispredict_pc_q, mispredict_pc_d;
  logic [CNT_WIDTH-1:0]  resolved_q, resolved_d;
  logic [CNT_WIDTH-1:0]  mis_total_q, mis_total_d;

  assign head_pc   = q_head[EW-1:1];
  assign head_pred = q_head[0];

  // A wrong-direction resolution and a flush both drop every younger entry
  assign mis_now = upd && (resolve_taken != head_pred);
  assign q_clear = flush || mis_now;

  inflight_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (lkp),
    .pop_i   (upd),
    .clear_i (q_clear),
    .wdata_i ({fetch_pc, pred_prediction}),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (inflight_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: any queue discard forces one recovery cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mis_now || flush) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: arbitration (updates win) and predictor port mux
  always_comb begin
    upd            = resolve_valid && !q_empty && (state_q == RUN);
    lkp            = fetch_valid && !upd && !q_full && (state_q == RUN) && !flush;
    resolve_ready  = upd;
    fetch_ready    = lkp;
    fetch_taken    = pred_prediction;
    pred_pc_bits   = fetch_pc;
    pred_update_en = 1'b0;
    pred_outcome   = 1'b0;
    if (upd) begin
      pred_pc_bits   = head_pc;
      pred_update_en = 1'b1;
      pred_outcome   = resolve_taken;
    end
  end

  // Statistics and mispredict next state; counters stick at all-ones
  always_comb begin
    mispredict_d    = mis_now;
    mispredict_pc_d = mis_now ? head_pc : mispredict_pc_q;
    resolved_d      = resolved_q;
    mis_total_d     = mis_total_q;
    if (upd && (resolved_q != '1))   resolved_d  = resolved_q + 1'b1;
    if (mis_now && (mis_total_q != '1)) mis_total_d = mis_total_q + 1'b1;
  end

  // Statistics and mispredict registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
      resolved_q      <= '0;
      mis_total_q     <= '0;
    end else begin
      mispredict_q    <= mispredict_d;
      mispredict_pc_q <= mispredict_pc_d;
      resolved_q      <= resolved_d;
      mis_total_q     <= mis_total_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign mispredict_pc    = mispredict_pc_q;
  assign resolved_total   = resolved_q;
  assign mispredict_total = mis_total_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_branch_update_scheduler
//   Scoreboard bench: a queue-based reference model predicts every cycle's
//   outputs; a negedge monitor pops and compares them.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_branch_update_scheduler;

  localparam int PCW  = 32;
  localparam int DEP  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            reset, fetch_valid, resolve_valid, resolve_taken, flush, pred_prediction;
  logic [PCW-1:0]  fetch_pc;
  logic            fetch_ready, fetch_taken, resolve_ready, pred_update_en, pred_outcome, mispredict;
  logic [PCW-1:0]  pred_pc_bits, mispredict_pc;
  logic [2:0]      inflight_count;
  logic [CW-1:0]   resolved_total, mispredict_total;

  branch_update_scheduler #(.PC_WIDTH(PCW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .fetch_taken(fetch_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .flush(flush), .pred_pc_bits(pred_pc_bits), .pred_prediction(pred_prediction),
    .pred_update_en(pred_update_en), .pred_outcome(pred_outcome),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc), .inflight_count(inflight_count),
    .resolved_total(resolved_total), .mispredict_total(mispredict_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          pred;
  } ent_t;

  typedef struct {
    bit          fr, ft, chk_ft, rr, uen, outc, mis;
    logic [31:0] ppc, mpc;
    int          cnt, rtot, mtot;
  } exp_t;

  // Reference model state
  ent_t m_q[$];
  bit   m_recover;
  bit   m_mis;
  logic [31:0] m_mis_pc;
  int   m_rtot, m_mtot;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("fetch_ready", 32'(fetch_ready), 32'(e.fr));
      if (e.chk_ft) check("fetch_taken", 32'(fetch_taken), 32'(e.ft));
      check("resolve_ready", 32'(resolve_ready), 32'(e.rr));
      check("pred_pc_bits", pred_pc_bits, e.ppc);
      check("pred_update_en", 32'(pred_update_en), 32'(e.uen));
      check("pred_outcome", 32'(pred_outcome), 32'(e.outc));
      check("mispredict", 32'(mispredict), 32'(e.mis));
      check("mispredict_pc", mispredict_pc, e.mpc);
      check("inflight_count", 32'(inflight_count), 32'(e.cnt));
      check("resolved_total", 32'(resolved_total), 32'(e.rtot));
      check("mispredict_total", 32'(mispredict_total), 32'(e.mtot));
    end
  end

  // One clock cycle: drive inputs, record expected outputs, advance the model
  task automatic step(input bit r, input bit fv, input logic [31:0] pc, input bit pp,
                      input bit rv, input bit rt, input bit fl);
    exp_t e;
    bit   upd, lkp, newmis;
    ent_t h;
    reset = r; fetch_valid = fv; fetch_pc = pc; pred_prediction = pp;
    resolve_valid = rv; resolve_taken = rt; flush = fl;

    upd = rv && (m_q.size() > 0) && !m_recover;
    lkp = fv && !upd && (m_q.size() < DEP) && !m_recover && !fl;
    e.fr = lkp; e.ft = pp; e.chk_ft = lkp; e.rr = upd;
    e.uen = upd; e.outc = upd ? rt : 1'b0;
    e.ppc = upd ? m_q[0].pc : pc;
    e.mis = m_mis; e.mpc = m_mis_pc; e.cnt = m_q.size();
    e.rtot = m_rtot; e.mtot = m_mtot;
    exp_q.push_back(e);

    if (r) begin
      m_q.delete(); m_recover = 0; m_mis = 0; m_mis_pc = '0; m_rtot = 0; m_mtot = 0;
    end else begin
      newmis = 0;
      if (upd) begin
        h = m_q.pop_front();
        if (m_rtot < CMAX) m_rtot++;
        if (rt != h.pred) begin
          newmis = 1; m_mis_pc = h.pc;
          if (m_mtot < CMAX) m_mtot++;
          m_q.delete();
        end
      end
      if (lkp) m_q.push_back('{pc: pc, pred: pp});
      if (fl) m_q.delete();
      m_recover = !m_recover && (newmis || fl);
      m_mis = newmis;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input bit pp);
    step(0, 1, pc, pp, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit rv, rt, fv, fl, r;
    reset = 1; fetch_valid = 0; fetch_pc = '0; pred_prediction = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;
    m_recover = 0; m_mis = 0; m_mis_pc = '0; m_rtot = 0; m_mtot = 0;
    @(posedge clk); #1;  // DUT state is unknown before the first reset edge
    step(1, 0, 0, 0, 0, 0, 0);

    // First lookup
    push(32'h100, 1);
    idle();

    // Fill to full, hold a fifth, then one correct resolve frees a slot
    step(1, 0, 0, 0, 0, 0, 0);
    push(32'h100, 1); push(32'h104, 0); push(32'h108, 1); push(32'h10c, 0);
    step(0, 1, 32'h110, 1, 0, 0, 0);
    step(0, 1, 32'h110, 1, 1, 1, 0);
    step(0, 1, 32'h110, 1, 0, 0, 0);
    idle();

    // Update wins the port over a concurrent lookup
    step(1, 0, 0, 0, 0, 0, 0);
    push(32'h100, 1); push(32'h104, 0);
    step(0, 1, 32'h300, 0, 1, 1, 0);
    idle();

    // Mispredict on the oldest entry discards the younger ones
    step(1, 0, 0, 0, 0, 0, 0);
    push(32'h200, 1); push(32'h204, 1); push(32'h208, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h400, 1, 0, 0, 0);
    step(0, 1, 32'h400, 1, 0, 0, 0);
    check("directed_mis_total", 32'(mispredict_total), 32'd1);
    idle();

    // Flush coincident with a correct resolve
    step(1, 0, 0, 0, 0, 0, 0);
    push(32'h500, 0); push(32'h504, 1); push(32'h508, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h600, 1, 0, 0, 0);
    step(0, 1, 32'h600, 1, 0, 0, 0);
    idle();

    // Saturation of the resolution counter
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      push(32'h1000 + 32'(i*4), i[0]);
      step(0, 0, 0, 0, 1, i[0], 0);
    end
    idle();
    check("directed_resolved_sat", 32'(resolved_total), 32'd15);

    // Randomized traffic, including occasional mid-traffic resets
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      fv = ($urandom_range(0, 99) < 70);
      rv = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 4);
      if (m_q.size() > 0) rt = m_q[0].pred ^ ($urandom_range(0, 4) == 0);
      else                rt = 1'($urandom);
      step(r, fv, {$urandom, 2'b00} & 32'hffff_fffc, 1'($urandom), rv, rt, fl);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
Time-multiplexes the tournament predictor's single pc_bits/update port between fetch-side lookups and execute-side resolutions. Records each looked-up branch (PC, predicted direction) in an in-order in-flight queue. On resolution it issues the predictor update and raises a registered mispredict pulse. Sits between fetch, the tournament predictor, and the branch-resolution stage.

Parameters:
PC_WIDTH, 32, width of branch PCs
DEPTH, 4, in-flight queue entries (power of 2, >=2)
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch presents a branch for prediction
fetch_pc  in  PC_WIDTH  branch PC
fetch_ready  out  1  lookup accepted this cycle
fetch_taken  out  1  predicted direction, valid when fetch_valid&&fetch_ready
resolve_valid  in  1  oldest in-flight branch resolved
resolve_taken  in  1  actual direction
resolve_ready  out  1  resolution accepted this cycle
flush  in  1  external pipeline flush
pred_pc_bits  out  PC_WIDTH  to predictor pc_bits
pred_prediction  in  1  from predictor prediction (combinational)
pred_update_en  out  1  to predictor update_en
pred_outcome  out  1  to predictor outcome
mispredict  out  1  one-cycle registered pulse
mispredict_pc  out  PC_WIDTH  PC of mispredicted branch, held until next mispredict
inflight_count  out  $clog2(DEPTH)+1  queue occupancy
resolved_total  out  CNT_WIDTH  saturating count of resolutions
mispredict_total  out  CNT_WIDTH  saturating count of mispredicts

Behaviour:
- Reset (sync, high): queue empty, state RUN, mispredict=0, mispredict_pc=0, both counters=0. Reset overrides all other inputs in the same cycle.
- States: RUN, RECOVER. RUN->RECOVER on the edge that registers a mispredict or accepts flush. RECOVER->RUN unconditionally after 1 cycle. In RECOVER, fetch_ready=0; resolve_ready=0 because the queue is empty.
- Arbitration (combinational, per cycle): update has priority.
  - upd = resolve_valid && count>0 && state==RUN.
  - lkp = fetch_valid && !upd && count<DEPTH && state==RUN && !flush.
  - resolve_ready=upd; fetch_ready=lkp.
- Port mux:
  - upd: pred_pc_bits=head.pc, pred_update_en=1, pred_outcome=resolve_taken.
  - Otherwise: pred_pc_bits=fetch_pc, pred_update_en=0, pred_outcome=0.
  - fetch_taken=pred_prediction (0 latency, valid only when lkp).
- Lookup: on lkp, push {fetch_pc, pred_prediction} at the edge.
- Resolve: on upd, pop the head at the edge.
  - resolved_total+1, saturating at all-ones.
  - If resolve_taken != head.pred: mispredict=1 next cycle, mispredict_pc=head.pc, mispredict_total+1 (saturating), and all remaining younger entries are discarded at the same edge (count->0).
  - mispredict defaults to 0 on every other cycle.
- Flush:
  - Clears the queue at the edge and enters RECOVER.
  - If upd and flush coincide, the update is still issued (pred_update_en=1 that cycle) and counted, then the queue clears.
  - A flush does not itself pulse mispredict.
- Queue: circular buffer with wrapping read/write pointers.
  - Full (count==DEPTH): fetch_ready=0.
  - Empty: resolve_ready=0; resolve_valid while empty is ignored (no update, no count).
- Simultaneous push and pop are impossible by construction (upd excludes lkp).

Decomposition:
- Shared package branch_pkg: state enum {RUN, RECOVER}; inflight-entry struct {pc, pred}; default PC_WIDTH constant.
- One sub-module, inflight_fifo: parameterised sync FIFO with push/pop/clear and full/empty/count outputs.
- Arbitration, FSM and counters live in the top module.

Test Plan:
- Reset, then fetch_valid with pc=0x100 and pred_prediction=1 -> fetch_ready=1, fetch_taken=1, pred_pc_bits=0x100, inflight_count=1 next cycle.
- 4 lookups with DEPTH=4, 5th fetch_valid held -> fetch_ready=0, count stays 4. Then one correct resolve -> 5th accepted the cycle after the pop.
- Queue [0x100/T, 0x104/NT], resolve_taken=1 while fetch_valid=1 -> resolve_ready=1, fetch_ready=0, pred_update_en=1, pred_pc_bits=0x100, pred_outcome=1; no mispredict; count 1.
- Queue [0x200/T, 0x204/T, 0x208/NT], resolve_taken=0 -> next cycle mispredict=1, mispredict_pc=0x200, count=0, mispredict_total=1; following cycle fetch_ready=0 (RECOVER), then RUN.
- flush coincident with a correct resolve on a 3-entry queue -> update issued, resolved_total+1, count=0, mispredict=0, one RECOVER cycle.
- Saturation: preload counters near max (CNT_WIDTH=4), run 20 resolutions -> resolved_total sticks at 15; mid-traffic reset -> all outputs return to reset values next cycle.
